// File: rtl/j1_io_fabric.sv
// j1_io_fabric
//   I/O interconnect between the J1 core and its memory-mapped peripherals.
//   The upper address byte selects one of N_SLAVES channels (or the internal
//   status page). Mapped accesses run through IDLE -> ACCESS -> [WAIT] -> DONE
//   and stall the CPU until DONE. Slaves flagged in ACK_MASK may insert wait
//   states with s_ack; a WAIT longer than TIMEOUT_CYCLES is aborted with 16'hDEAD.
//   Unmapped pages and the status page answer in zero wait states.
//
// Ports
//   sys_clk_i, sys_rst_i   clock, asynchronous active-low reset
//   j1_io_rd/wr/addr/dout  CPU strobes (held while stalled), address, write data
//   j1_io_din, j1_io_stall read data and hold request to the CPU
//   s_cs, s_rd, s_wr       one-hot slave select and slave strobes
//   s_addr, s_din          registered address / write data to the slaves
//   s_dout, s_ack          per-slave read data (16b slices) and completion
//   irq_err                OR of the sticky error bits
module j1_io_fabric #(
    parameter int                    N_SLAVES       = 10,
    parameter logic [N_SLAVES*8-1:0] PAGE_MAP       = {8'h65, 8'h64, 8'h6E, 8'h6D, 8'h6C,
                                                       8'h6B, 8'h6A, 8'h69, 8'h68, 8'h67},
    parameter logic [N_SLAVES-1:0]   ACK_MASK       = {N_SLAVES{1'b0}},
    parameter int                    TIMEOUT_CYCLES = 16,
    parameter logic [7:0]            STAT_PAGE      = 8'h7F
) (
    input  logic                     sys_clk_i,
    input  logic                     sys_rst_i,
    input  logic                     j1_io_rd,
    input  logic                     j1_io_wr,
    input  logic [15:0]              j1_io_addr,
    input  logic [15:0]              j1_io_dout,
    output logic [15:0]              j1_io_din,
    output logic                     j1_io_stall,
    output logic [N_SLAVES-1:0]      s_cs,
    output logic                     s_rd,
    output logic                     s_wr,
    output logic [15:0]              s_addr,
    output logic [15:0]              s_din,
    input  logic [N_SLAVES*16-1:0]   s_dout,
    input  logic [N_SLAVES-1:0]      s_ack,
    output logic                     irq_err
);
    localparam int KW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic          wr_q, wr_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   wdat_q, wdat_d;
    logic [15:0]   rdata_q, rdata_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          unm_q, unm_d;
    logic          tmo_q, tmo_d;
    logic          irq_q, irq_d;
    logic [7:0]    ecnt_q, ecnt_d;
    logic [15:0]   eaddr_q, eaddr_d;

    logic          strobe, is_stat, is_map, hit, ack_k;
    logic          set_unm, set_tmo, clr;
    logic [KW-1:0] hit_k;
    logic [15:0]   stat_rd;
    logic [15:0]   sdo [N_SLAVES];

    for (genvar g = 0; g < N_SLAVES; g++) begin : g_sdo
        assign sdo[g] = s_dout[g*16 +: 16];
    end

    // Page decode; scanning downwards lets the lowest matching slave win.
    always_comb begin
        hit   = 1'b0;
        hit_k = '0;
        for (int k = N_SLAVES - 1; k >= 0; k--) begin
            if (j1_io_addr[15:8] == PAGE_MAP[k*8 +: 8]) begin
                hit   = 1'b1;
                hit_k = KW'(k);
            end
        end
    end

    assign strobe  = j1_io_rd | j1_io_wr;
    assign is_stat = (j1_io_addr[15:8] == STAT_PAGE);
    assign is_map  = hit & ~is_stat;
    // Slaves without a real ack complete in ACCESS.
    assign ack_k   = s_ack[k_q] | ~ACK_MASK[k_q];

    always_comb begin
        case (j1_io_addr[3:0])
            4'd0:    stat_rd = {ecnt_q, 6'b0, unm_q, tmo_q};
            4'd1:    stat_rd = eaddr_q;
            4'd2:    stat_rd = {8'h00, 8'(N_SLAVES)};
            default: stat_rd = 16'h0000;
        endcase
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        rdata_d = rdata_q;
        tcnt_d  = tcnt_q;
        set_unm = 1'b0;
        set_tmo = 1'b0;
        clr     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (strobe) begin
                    if (is_stat) begin
                        clr = j1_io_wr && (j1_io_addr[3:0] == 4'd0);
                    end else if (is_map) begin
                        k_d     = hit_k;
                        wr_d    = j1_io_wr;  // rd&wr together is a write
                        addr_d  = j1_io_addr;
                        wdat_d  = j1_io_dout;
                        rdata_d = 16'h0000;
                        state_d = S_ACCESS;
                    end else begin
                        set_unm = 1'b1;
                    end
                end
            end
            S_ACCESS: begin
                if (ack_k) begin
                    if (!wr_q) rdata_d = sdo[k_q];
                    state_d = S_DONE;
                end else begin
                    tcnt_d  = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ack_k) begin
                    if (!wr_q) rdata_d = sdo[k_q];
                    state_d = S_DONE;
                end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d = 16'hDEAD;
                    set_tmo = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Error bookkeeping; a status clear beats any error raised in the same cycle.
    always_comb begin
        unm_d   = unm_q;
        tmo_d   = tmo_q;
        ecnt_d  = ecnt_q;
        eaddr_d = eaddr_q;
        if (clr) begin
            unm_d  = 1'b0;
            tmo_d  = 1'b0;
            ecnt_d = 8'd0;
        end else if (set_unm || set_tmo) begin
            if (set_unm) unm_d = 1'b1;
            if (set_tmo) tmo_d = 1'b1;
            if (ecnt_q != 8'hFF) ecnt_d = ecnt_q + 8'd1;
            eaddr_d = set_unm ? j1_io_addr : addr_q;
        end
        irq_d = unm_d | tmo_d;
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            wr_q    <= 1'b0;
            addr_q  <= 16'h0000;
            wdat_q  <= 16'h0000;
            rdata_q <= 16'h0000;
            tcnt_q  <= '0;
            unm_q   <= 1'b0;
            tmo_q   <= 1'b0;
            irq_q   <= 1'b0;
            ecnt_q  <= 8'd0;
            eaddr_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            rdata_q <= rdata_d;
            tcnt_q  <= tcnt_d;
            unm_q   <= unm_d;
            tmo_q   <= tmo_d;
            irq_q   <= irq_d;
            ecnt_q  <= ecnt_d;
            eaddr_q <= eaddr_d;
        end
    end

    always_comb begin
        s_cs = '0;
        if (state_q == S_ACCESS || state_q == S_WAIT) s_cs[k_q] = 1'b1;
    end

    always_comb begin
        j1_io_din = 16'h0000;
        if (state_q == S_IDLE && strobe && is_stat && !j1_io_wr) j1_io_din = stat_rd;
        else if (state_q == S_DONE && !wr_q)                     j1_io_din = rdata_q;
    end

    assign j1_io_stall = (state_q == S_IDLE && strobe && is_map) ||
                         state_q == S_ACCESS || state_q == S_WAIT;
    assign s_rd    = (state_q == S_ACCESS) & ~wr_q;
    assign s_wr    = (state_q == S_ACCESS) &  wr_q;
    assign s_addr  = addr_q;
    assign s_din   = wdat_q;
    assign irq_err = irq_q;

endmodule

// File: tb/tb_j1_io_fabric.sv
// Bench for j1_io_fabric: directed scenarios plus randomized accesses, each
// checked against a transaction-level model (expected stall length, data and
// sticky error state derived from page tables and wait-state counts).
module tb_j1_io_fabric;
    localparam int            N    = 10;
    localparam logic [N-1:0]  AMSK = 10'b0000001100;
    localparam int            TMO  = 16;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          rd = 1'b0, wr = 1'b0;
    logic [15:0]   addr = 16'h0, dout = 16'h0;
    logic [15:0]   din, saddr, sdin;
    logic          stall, srd, swr, irq;
    logic [N-1:0]  cs;
    logic [N*16-1:0] sdout = '0;
    logic [N-1:0]  sack  = '0;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] pages [N] = '{8'h67, 8'h68, 8'h69, 8'h6A, 8'h6B,
                              8'h6C, 8'h6D, 8'h6E, 8'h64, 8'h65};

    // reference model state
    logic        m_unm = 1'b0, m_tmo = 1'b0;
    int          m_cnt = 0;
    logic [15:0] m_eaddr = 16'h0;

    always #5 clk = ~clk;

    j1_io_fabric #(.N_SLAVES(N), .ACK_MASK(AMSK), .TIMEOUT_CYCLES(TMO), .STAT_PAGE(8'h7F)) dut (
        .sys_clk_i(clk), .sys_rst_i(rst_n),
        .j1_io_rd(rd), .j1_io_wr(wr), .j1_io_addr(addr), .j1_io_dout(dout),
        .j1_io_din(din), .j1_io_stall(stall),
        .s_cs(cs), .s_rd(srd), .s_wr(swr), .s_addr(saddr), .s_din(sdin),
        .s_dout(sdout), .s_ack(sack), .irq_err(irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] m_status(input logic [3:0] off);
        case (off)
            4'd0:    return {8'(m_cnt), 6'b0, m_unm, m_tmo};
            4'd1:    return m_eaddr;
            4'd2:    return 16'(N);
            default: return 16'h0000;
        endcase
    endfunction

    function automatic void m_error(input bit tmo, input logic [15:0] a);
        if (tmo) m_tmo = 1'b1;
        else     m_unm = 1'b1;
        if (m_cnt < 255) m_cnt++;
        m_eaddr = a;
    endfunction

    // One CPU access, entered just after a rising edge. dly = WAIT cycle in
    // which an ack-capable slave acks (0 = during ACCESS). hold keeps the
    // strobe up so the next call forms a back-to-back access.
    task automatic io(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                      input logic [15:0] rv, input int dly, input bit hold, input string tag);
        int k, eff, exp_stall, n_stall, n_cs, n_rd, n_wr, bad;
        bit st, mapped, tmo_hit, done;
        logic [15:0] exp_din, got_din;
        logic [N-1:0] cs_exp;
        k = -1;
        for (int i = 0; i < N; i++) if (k < 0 && pages[i] == a[15:8]) k = i;
        st = (a[15:8] == 8'h7F);
        mapped = !st && (k >= 0);
        tmo_hit = 1'b0; exp_stall = 0; exp_din = 16'h0; cs_exp = '0;
        if (st) exp_din = (r && !w) ? m_status(a[3:0]) : 16'h0;
        else if (mapped) begin
            eff = AMSK[k] ? dly : 0;
            tmo_hit = (eff > TMO);
            exp_stall = tmo_hit ? 2 + TMO : 2 + eff;
            exp_din = w ? 16'h0 : (tmo_hit ? 16'hDEAD : rv);
            cs_exp[k] = 1'b1;
        end
        rd = r; wr = w; addr = a; dout = d;
        for (int i = 0; i < N; i++) sdout[i*16 +: 16] = 16'($urandom);
        if (mapped) sdout[k*16 +: 16] = rv;
        sack = '0;
        n_stall = 0; n_cs = 0; n_rd = 0; n_wr = 0; bad = 0; done = 1'b0; got_din = 16'h0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (srd) n_rd++;
            if (swr) n_wr++;
            if (!stall) begin
                done = 1'b1;
                got_din = din;
                if (cs != '0) bad++;
            end else begin
                n_stall++;
                if (cs != '0) begin
                    n_cs++;
                    if (cs !== cs_exp || saddr !== a || (w && sdin !== d)) bad++;
                end
                sack = N'($urandom);
                if (mapped) sack[k] = (n_cs == dly + 1);
            end
        end
        chk({tag, ".done"},  32'(done), 32'd1);
        chk({tag, ".stall"}, 32'(n_stall), 32'(exp_stall));
        chk({tag, ".din"},   32'(got_din), 32'(exp_din));
        chk({tag, ".s_rd"},  32'(n_rd), 32'(mapped && !w));
        chk({tag, ".s_wr"},  32'(n_wr), 32'(mapped && w));
        chk({tag, ".s_cs"},  32'(n_cs), mapped ? 32'(exp_stall - 1) : 32'd0);
        chk({tag, ".bus"},   32'(bad), 32'd0);
        if (st) begin
            if (w && a[3:0] == 4'd0) begin m_unm = 1'b0; m_tmo = 1'b0; m_cnt = 0; end
        end else if (!mapped) m_error(1'b0, a);
        else if (tmo_hit)     m_error(1'b1, a);
        @(posedge clk); #1;
        if (!hold) begin rd = 1'b0; wr = 1'b0; end
        sack = '0;
        chk({tag, ".irq"}, 32'(irq), 32'(m_unm | m_tmo));
    endtask

    initial begin
        int sel, kk, mode;
        logic [15:0] ra;
        // reset state
        #3;
        chk("rst.cs", 32'(cs), 32'd0);
        chk("rst.stall", 32'(stall), 32'd0);
        chk("rst.din", 32'(din), 32'd0);
        chk("rst.saddr", 32'(saddr), 32'd0);
        chk("rst.sdin", 32'(sdin), 32'd0);
        chk("rst.strb", 32'({srd, swr}), 32'd0);
        chk("rst.irq", 32'(irq), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        io(1'b1, 1'b0, 16'h6700, 16'h0, 16'h1234, 0, 1'b0, "t2");
        io(1'b0, 1'b1, 16'h6902, 16'hA5A5, 16'h0, 3, 1'b0, "t3");
        io(1'b1, 1'b0, 16'h6910, 16'h0, 16'h5555, 100, 1'b0, "t4");
        io(1'b1, 1'b0, 16'h7F00, 16'h0, 16'h0, 0, 1'b0, "t4.stat0");
        io(1'b1, 1'b0, 16'h5A00, 16'h0, 16'h0, 0, 1'b0, "t5");
        io(1'b1, 1'b0, 16'h7F01, 16'h0, 16'h0, 0, 1'b0, "t5.eaddr");
        io(1'b1, 1'b0, 16'h7F00, 16'h0, 16'h0, 0, 1'b0, "t5.stat0");
        io(1'b0, 1'b1, 16'h7F00, 16'hFFFF, 16'h0, 0, 1'b0, "t5.clr");
        io(1'b1, 1'b0, 16'h7F00, 16'h0, 16'h0, 0, 1'b0, "t5.after");
        io(1'b1, 1'b0, 16'h7F02, 16'h0, 16'h0, 0, 1'b0, "stat2");
        io(1'b1, 1'b0, 16'h7F07, 16'h0, 16'h0, 0, 1'b0, "stat7");
        io(1'b1, 1'b0, 16'h6700, 16'h0, 16'h1111, 0, 1'b1, "t6a");
        io(1'b1, 1'b0, 16'h6800, 16'h0, 16'h2222, 0, 1'b0, "t6b");
        io(1'b1, 1'b1, 16'h6A00, 16'h7777, 16'h9999, 1, 1'b0, "both.map");
        io(1'b1, 1'b1, 16'h7F01, 16'h1234, 16'h0, 0, 1'b0, "both.stat");
        io(1'b1, 1'b0, 16'h6A04, 16'h0, 16'hBEEF, 16, 1'b0, "edge16");
        io(1'b1, 1'b0, 16'h6A05, 16'h0, 16'hBEEF, 17, 1'b0, "edge17");
        io(1'b0, 1'b1, 16'h6906, 16'h4321, 16'h0, 30, 1'b0, "wr.tmo");

        // error counter saturation
        for (int n = 0; n < 260; n++)
            io(1'b1, 1'b0, {8'($urandom_range(0, 8'h5F)), 8'($urandom)}, 16'h0, 16'h0, 0, 1'b0, "sat");
        io(1'b1, 1'b0, 16'h7F00, 16'h0, 16'h0, 0, 1'b0, "sat.stat0");

        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 9);
            mode = $urandom_range(0, 3);
            if (sel < 6) begin
                kk = $urandom_range(0, N - 1);
                ra = {pages[kk], 8'($urandom)};
            end else if (sel < 8) ra = {8'h7F, 4'h0, 8'h0, 4'($urandom_range(0, 3))};
            else ra = {8'($urandom_range(0, 8'h5F)), 8'($urandom)};
            io(mode != 2, mode >= 2, ra, 16'($urandom), 16'($urandom),
               $urandom_range(0, 20), 1'b0, "rnd");
        end

        // reset dropped in the middle of a WAIT phase
        io(1'b1, 1'b0, 16'h1200, 16'h0, 16'h0, 0, 1'b0, "t1.err");
        rd = 1'b1; addr = 16'h6900; sack = '0;
        repeat (4) @(negedge clk);
        chk("t1.inwait", 32'(cs), 32'(1 << 2));
        rst_n = 1'b0; rd = 1'b0;
        #1;
        chk("t1.cs", 32'(cs), 32'd0);
        chk("t1.stall", 32'(stall), 32'd0);
        chk("t1.din", 32'(din), 32'd0);
        chk("t1.irq", 32'(irq), 32'd0);
        m_unm = 1'b0; m_tmo = 1'b0; m_cnt = 0; m_eaddr = 16'h0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        io(1'b1, 1'b0, 16'h7F00, 16'h0, 16'h0, 0, 1'b0, "t1.stat0");
        io(1'b1, 1'b0, 16'h7F01, 16'h0, 16'h0, 0, 1'b0, "t1.stat1");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
